// File: rtl/mem_bank_access_ctrl_if.sv
// Requester-side and memory-side bundle for the shared 4-bank byte memory.
// The controller uses the slave modport; the requesters plus memory system use master.
interface mem_bank_access_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [2*N_REQ-1:0]      req_addr;
  logic [DATA_W*N_REQ-1:0] req_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              mem_sel;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_store;

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, done, rdata, mem_sel, mem_data, mem_store
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, done, rdata, mem_sel, mem_data, mem_store
  );
endinterface

// File: rtl/mem_bank_access_ctrl.sv
// Round-robin arbiter/sequencer sharing a 4-bank byte memory among 4 requesters.
// One transaction at a time: grant (ACCESS, 1 cycle) then completion pulse (DONE, 1 cycle).
module mem_bank_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bank_access_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_rr_ptr, w_rr_ptr_next;
  logic [1:0]        r_owner, w_owner_next;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [N_REQ-1:0]  r_done, w_done_next;
  logic [DATA_W-1:0] r_rdata, w_rdata_next;
  logic [1:0]        r_mem_sel, w_mem_sel_next;
  logic [DATA_W-1:0] r_mem_data, w_mem_data_next;
  logic              r_mem_store, w_mem_store_next;

  logic [1:0]        w_addr  [N_REQ];
  logic [DATA_W-1:0] w_wdata [N_REQ];
  logic [N_REQ-1:0]  w_req_rot;
  logic [1:0]        w_win_off;
  logic [1:0]        w_winner;

  // w_req_rot[k] is the request of requester (rr_ptr + k), so the lowest set bit wins.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_addr[gi]    = bus.req_addr[2*gi +: 2];
      assign w_wdata[gi]   = bus.req_wdata[DATA_W*gi +: DATA_W];
      assign w_req_rot[gi] = bus.req[r_rr_ptr + 2'(gi)];
    end
  endgenerate

  always_comb begin
    w_win_off = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_win_off = 2'(i);
    end
  end

  assign w_winner = r_rr_ptr + w_win_off;

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_owner_next     = r_owner;
    w_gnt_next       = r_gnt;
    w_done_next      = r_done;
    w_rdata_next     = r_rdata;
    w_mem_sel_next   = r_mem_sel;
    w_mem_data_next  = r_mem_data;
    w_mem_store_next = r_mem_store;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_owner_next     = w_winner;
          w_mem_sel_next   = w_addr[w_winner];
          w_mem_data_next  = w_wdata[w_winner];
          w_mem_store_next = bus.req_we[w_winner];
          w_gnt_next       = N_REQ'(1) << w_winner;
          w_state_next     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // r_mem_store is high for the whole ACCESS cycle exactly when this is a write.
        if (!r_mem_store) w_rdata_next = bus.mem_rdata;
        w_mem_store_next = 1'b0;
        w_gnt_next       = '0;
        w_done_next      = N_REQ'(1) << r_owner;
        w_state_next     = S_DONE;
      end
      S_DONE: begin
        w_done_next   = '0;
        w_rr_ptr_next = r_owner + 2'd1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd0;
      r_owner     <= 2'd0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_sel   <= 2'd0;
      r_mem_data  <= '0;
      r_mem_store <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_owner     <= w_owner_next;
      r_gnt       <= w_gnt_next;
      r_done      <= w_done_next;
      r_rdata     <= w_rdata_next;
      r_mem_sel   <= w_mem_sel_next;
      r_mem_data  <= w_mem_data_next;
      r_mem_store <= w_mem_store_next;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_store = r_mem_store;
endmodule

// File: tb/tb_mem_bank_access_ctrl.sv
// Scoreboard bench: stimulus predicts service order and data per batch; a monitor
// compares every grant and completion against the queued expectations.
module tb_mem_bank_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bank_access_ctrl_if bus ();

  mem_bank_access_ctrl #(.DATA_W(8), .N_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory system: 4 byte banks, combinational read, write at the clock edge.
  logic [7:0] mem_sys [4];
  assign bus.mem_rdata = mem_sys[bus.mem_sel];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) mem_sys[k] <= 8'h00;
    end else if (bus.mem_store) begin
      mem_sys[bus.mem_sel] <= bus.mem_data;
    end
  end

  typedef struct {
    int         id;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t       exp_q[$];
  int         ref_ptr;
  logic [7:0] ref_mem [4];
  logic [7:0] exp_rdata;
  logic [3:0] prev_gnt;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters in the mask are all held until served, so service order is a plain
  // scan from the round-robin pointer; memory effects are applied in that order.
  task automatic issue(input logic [3:0] mask, input logic [3:0] we,
                       input logic [7:0] addr, input logic [31:0] wdata);
    txn_t t;
    int last;
    last = ref_ptr;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (ref_ptr + off) % 4;
      if (mask[i]) begin
        t.id    = i;
        t.we    = we[i];
        t.addr  = addr[2*i +: 2];
        t.wdata = wdata[8*i +: 8];
        t.rdata = ref_mem[t.addr];
        if (t.we) ref_mem[t.addr] = t.wdata;
        exp_q.push_back(t);
        last = i;
      end
    end
    if (mask != 4'b0) ref_ptr = (last + 1) % 4;
    bus.req = mask;
  endtask

  // Drops each requester's req when its done pulses; optionally drops req and
  // scrambles its inputs right after grant.
  task automatic wait_batch(input int max_cycles, input bit scramble);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && bus.req == 4'b0)) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (bus.done[i]) bus.req[i] = 1'b0;
        if (scramble && bus.gnt[i] && $urandom_range(1, 0) == 1) begin
          bus.req[i]             = 1'b0;
          bus.req_we[i]          = ~bus.req_we[i];
          bus.req_addr[2*i +: 2] = 2'($urandom);
          bus.req_wdata[8*i +: 8] = 8'($urandom);
        end
      end
      if (cyc > max_cycles) begin
        chk("batch_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        bus.req = 4'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req = 4'b0;
    exp_q.delete();
    ref_ptr = 0;
    for (int k = 0; k < 4; k++) ref_mem[k] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor
  initial begin
    txn_t t;
    prev_gnt  = 4'b0;
    exp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_gnt  = 4'b0;
        exp_rdata = 8'h00;
        continue;
      end
      chk("gnt_done_overlap", 32'(bus.gnt & bus.done), 32'd0);
      if (bus.gnt == 4'b0) chk("store_without_gnt", 32'(bus.mem_store), 32'd0);
      if (bus.gnt != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 32'(bus.gnt), 32'd0);
        end else begin
          t = exp_q[0];
          chk("gnt_onehot", 32'(bus.gnt), 32'(4'b1 << t.id));
          chk("mem_sel", 32'(bus.mem_sel), 32'(t.addr));
          chk("mem_store", 32'(bus.mem_store), 32'(t.we));
          if (t.we) chk("mem_data", 32'(bus.mem_data), 32'(t.wdata));
        end
      end
      if (bus.done != 4'b0) begin
        chk("done_follows_gnt", 32'(bus.done), 32'(prev_gnt));
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          t = exp_q.pop_front();
          chk("done_onehot", 32'(bus.done), 32'(4'b1 << t.id));
          if (t.we) chk("mem_commit", 32'(mem_sys[t.addr]), 32'(t.wdata));
          else exp_rdata = t.rdata;
          $display("txn req%0d %s bank%0d data %02h", t.id, t.we ? "WR" : "RD",
                   t.addr, t.we ? t.wdata : t.rdata);
        end
      end
      chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
      prev_gnt = bus.gnt;
    end
  end

  // Stimulus
  initial begin
    bus.req = 4'b0; bus.req_we = 4'b0; bus.req_addr = 8'h00; bus.req_wdata = 32'h0;
    ref_ptr = 0;
    for (int k = 0; k < 4; k++) ref_mem[k] = 8'h00;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
    chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
    chk("rst_mem_store", 32'(bus.mem_store), 32'd0);
    apply_reset();
    @(negedge clk);

    // Single write of A5 to bank 2 with exact latency, then read it back.
    issue(4'b0001, 4'b0001, 8'h02, 32'h0000_00A5);
    @(negedge clk);
    chk("wr_lat_gnt", 32'(bus.gnt), 32'h1);
    chk("wr_lat_store", 32'(bus.mem_store), 32'h1);
    @(negedge clk);
    chk("wr_lat_done", 32'(bus.done), 32'h1);
    chk("wr_store_one_cycle", 32'(bus.mem_store), 32'h0);
    bus.req = 4'b0;
    wait_batch(20, 1'b0);
    issue(4'b0001, 4'b0000, 8'h02, 32'h0);
    wait_batch(20, 1'b0);
    chk("rd_A5", 32'(bus.rdata), 32'hA5);

    // All four writing from reset: order 0,1,2,3 with data 10..13.
    apply_reset();
    issue(4'b1111, 4'b1111, 8'b11_10_01_00, 32'h1312_1110);
    wait_batch(40, 1'b0);

    // Round-robin skip: serve 1 (ptr -> 2), then 1001 gives 3 then 0.
    issue(4'b0010, 4'b0000, 8'h00, 32'h0);
    wait_batch(20, 1'b0);
    issue(4'b1001, 4'b0000, 8'b10_00_00_01, 32'h0);
    wait_batch(30, 1'b0);
    issue(4'b1111, 4'b0000, 8'b11_10_01_00, 32'h0);
    wait_batch(40, 1'b0);

    // Requester 1 writes 5A to bank 3; req and wdata change during ACCESS.
    issue(4'b0010, 4'b0010, 8'b00_00_11_00, 32'h0000_5A00);
    for (int c = 0; c < 5 && bus.gnt == 4'b0; c++) @(negedge clk);
    chk("drop_gnt", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    bus.req_wdata[15:8] = 8'hFF;
    wait_batch(20, 1'b0);
    chk("drop_commit", 32'(mem_sys[3]), 32'h5A);

    // Reset in the middle of a write ACCESS.
    issue(4'b0001, 4'b0001, 8'h01, 32'h0000_0077);
    for (int c = 0; c < 5 && bus.gnt == 4'b0; c++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_store", 32'(bus.mem_store), 32'h0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    apply_reset();
    issue(4'b0100, 4'b0000, 8'b00_01_00_00, 32'h0);
    wait_batch(20, 1'b0);

    // Read returning 3C, then idle hold.
    issue(4'b0100, 4'b0100, 8'b00_01_00_00, 32'h003C_0000);
    wait_batch(20, 1'b0);
    issue(4'b0100, 4'b0000, 8'b00_01_00_00, 32'h0);
    wait_batch(20, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      chk("idle_done", 32'(bus.done), 32'h0);
      chk("idle_store", 32'(bus.mem_store), 32'h0);
      chk("idle_rdata", 32'(bus.rdata), 32'h3C);
    end

    // Randomized batches with random post-grant input scrambling.
    for (int n = 0; n < 150; n++) begin
      issue(4'($urandom_range(15, 1)), 4'($urandom), 8'($urandom), $urandom);
      wait_batch(40, 1'b1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
